// File: rtl/cargador_dia_bcd_pkg.sv
// Shared constants, state encoding and BCD range check for the day loader.
package cargador_dia_bcd_pkg;

  localparam int         DIA_N       = 5;
  localparam logic [7:0] DIA_MIN_BCD = 8'h01;
  localparam logic [7:0] DIA_MAX_BCD = 8'h31;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ACC   = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  // Both digits must be decimal and the value must be a legal day of the month.
  function automatic logic bcd_day_ok(input logic [7:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd3) &&
           (v >= DIA_MIN_BCD) && (v <= DIA_MAX_BCD);
  endfunction

endpackage

// File: rtl/cargador_dia_bcd_if.sv
// Request/result bundle between a day-load requester and the BCD day loader.
interface cargador_dia_bcd_if
  import cargador_dia_bcd_pkg::*;
#(parameter int N = DIA_N);
  logic         load_req;
  logic [7:0]   data_bcd;
  logic         ready;
  logic         done;
  logic         error;
  logic [N-1:0] day_bin;

  modport master (output load_req, data_bcd, input ready, done, error, day_bin);
  modport slave  (input load_req, data_bcd, output ready, done, error, day_bin);
endinterface

// File: rtl/cargador_dia_bcd_detector_flanco.sv
// Rising-edge detector; the history bit resets high so a level held through reset is not an edge.
module detector_flanco (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic tick
);
  logic prev;

  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b1;
    else       prev <= in;
  end

  assign tick = in & ~prev;
endmodule

// File: rtl/cargador_dia_bcd.sv
// Converts a packed-BCD day (01..31) into day-1 in binary by repeated add-10 accumulation.
module cargador_dia_bcd
  import cargador_dia_bcd_pkg::*;
#(parameter int N = DIA_N) (
  input  logic                 clk,
  input  logic                 reset,
  cargador_dia_bcd_if.slave    bus
);
  state_t       state, state_d;
  logic [7:0]   cap, cap_d;
  logic [N-1:0] acc, acc_d;
  logic [N-1:0] tens_cnt, tens_d;
  logic [N-1:0] day_bin, day_d;
  logic         load_tick;

  detector_flanco u_flanco (
    .clk   (clk),
    .reset (reset),
    .in    (bus.load_req),
    .tick  (load_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cap      <= '0;
      acc      <= '0;
      tens_cnt <= '0;
      day_bin  <= '0;
    end else begin
      state    <= state_d;
      cap      <= cap_d;
      acc      <= acc_d;
      tens_cnt <= tens_d;
      day_bin  <= day_d;
    end
  end

  always_comb begin
    state_d = state;
    cap_d   = cap;
    acc_d   = acc;
    tens_d  = tens_cnt;
    day_d   = day_bin;
    case (state)
      IDLE: if (load_tick) begin
        cap_d   = bus.data_bcd;
        state_d = CHECK;
      end
      CHECK: if (!bcd_day_ok(cap)) begin
        state_d = ERR;
      end else begin
        acc_d   = N'(cap[3:0]);
        tens_d  = N'(cap[7:4]);
        state_d = ACC;
      end
      // One cycle per tens digit, plus the final cycle that commits the result.
      ACC: if (tens_cnt != '0) begin
        acc_d  = acc + N'(10);
        tens_d = tens_cnt - N'(1);
      end else begin
        day_d   = acc - N'(1);
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready   = (state == IDLE);
  assign bus.done    = (state == DONE);
  assign bus.error   = (state == ERR);
  assign bus.day_bin = day_bin;
endmodule

// File: tb/tb_cargador_dia_bcd.sv
// Self-checking bench for cargador_dia_bcd: directed table, corner sequences, random vs. model.
module tb_cargador_dia_bcd;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   day_model = 0;

  always #5 clk = ~clk;

  cargador_dia_bcd_if #(.N(5)) bus ();
  cargador_dia_bcd #(.N(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [7:0] data;
    bit         exp_err;
    int         exp_lat;
    int         exp_day;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: decimal value from the two digits; legal iff both digits decimal and 1..31.
  task automatic model(input logic [7:0] d, output bit err, output int lat, output int day);
    int t, u, v;
    t = int'(d) / 16;
    u = int'(d) % 16;
    v = t * 10 + u;
    err = !(u < 10 && t < 10 && v >= 1 && v <= 31);
    lat = err ? 2 : 3 + t;
    day = err ? day_model : v - 1;
  endtask

  // One request; optional data scramble and a second edge while busy.
  task automatic convert(input logic [7:0] d, input bit exp_err, input int exp_lat,
                         input int exp_day, input bit scramble, input bit reedge);
    int n_done = 0, n_err = 0, lat = -1, day_at = -1, overlap = 0, bad_rdy = 0, w = 0;
    while (!bus.ready && w < 50) begin step(); w++; end
    chk("ready_wait", int'(bus.ready), 1);
    bus.data_bcd = d;
    bus.load_req = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      step();
      if (bus.done || bus.error) begin
        if (lat < 0) lat = j;
        if (bus.done) begin n_done++; day_at = int'(bus.day_bin); end
        if (bus.error) begin n_err++; day_at = int'(bus.day_bin); end
      end
      if (bus.done && bus.error) overlap++;
      if (int'(bus.ready) != ((j <= exp_lat) ? 0 : 1)) bad_rdy++;
      if (j == 1) begin
        bus.load_req = 1'b0;
        if (scramble) bus.data_bcd = 8'($urandom);
      end
      if (j == 2 && reedge) bus.load_req = 1'b1;
      if (j == 4) bus.load_req = 1'b0;
    end
    chk($sformatf("done_cnt[%h]", d), n_done, exp_err ? 0 : 1);
    chk($sformatf("err_cnt[%h]", d), n_err, exp_err ? 1 : 0);
    chk($sformatf("latency[%h]", d), lat, exp_lat);
    chk($sformatf("day_bin[%h]", d), day_at, exp_day);
    chk($sformatf("overlap[%h]", d), overlap, 0);
    chk($sformatf("ready[%h]", d), bad_rdy, 0);
    day_model = exp_day;
  endtask

  vec_t tbl[12];

  initial begin
    int n_done;
    bit e; int l, dy;
    logic [7:0] d;

    tbl[0]  = '{8'h15, 1'b0, 4, 14};
    tbl[1]  = '{8'h31, 1'b0, 6, 30};
    tbl[2]  = '{8'h32, 1'b1, 2, 30};
    tbl[3]  = '{8'h1A, 1'b1, 2, 30};
    tbl[4]  = '{8'h00, 1'b1, 2, 30};
    tbl[5]  = '{8'h01, 1'b0, 3, 0};
    tbl[6]  = '{8'h3A, 1'b1, 2, 0};
    tbl[7]  = '{8'h40, 1'b1, 2, 0};
    tbl[8]  = '{8'h29, 1'b0, 5, 28};
    tbl[9]  = '{8'h10, 1'b0, 4, 9};
    tbl[10] = '{8'h30, 1'b0, 6, 29};
    tbl[11] = '{8'h0F, 1'b1, 2, 29};

    // Reset with load_req already high: no conversion may start afterwards.
    reset = 1'b1;
    bus.load_req = 1'b1;
    bus.data_bcd = 8'h15;
    step(); step();
    reset = 1'b0;
    chk("rst_ready", int'(bus.ready), 1);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_error", int'(bus.error), 0);
    chk("rst_day", int'(bus.day_bin), 0);
    step(); step(); step();
    chk("held_no_conv", int'(bus.ready), 1);
    bus.load_req = 1'b0;
    step();

    foreach (tbl[i])
      convert(tbl[i].data, tbl[i].exp_err, tbl[i].exp_lat, tbl[i].exp_day, 1'b1, i[0]);

    // Level held for 20 cycles: exactly one conversion.
    bus.data_bcd = 8'h09;
    bus.load_req = 1'b1;
    n_done = 0;
    for (int j = 0; j < 25; j++) begin
      step();
      if (j == 19) bus.load_req = 1'b0;
      if (bus.done) n_done++;
    end
    chk("hold_done_cnt", n_done, 1);
    chk("hold_day", int'(bus.day_bin), 8);
    day_model = 8;

    // Reset during ACC of 0x31 aborts and clears the result.
    bus.data_bcd = 8'h31;
    bus.load_req = 1'b1;
    step(); bus.load_req = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_ready", int'(bus.ready), 1);
    chk("abort_day", int'(bus.day_bin), 0);
    n_done = 0;
    for (int j = 0; j < 8; j++) begin step(); if (bus.done) n_done++; end
    chk("abort_no_done", n_done, 0);
    day_model = 0;

    // Reset and a rising edge in the same cycle: reset wins.
    bus.data_bcd = 8'h12;
    bus.load_req = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_done = 0;
    for (int j = 0; j < 8; j++) begin step(); if (bus.done || !bus.ready) n_done++; end
    chk("rst_prio", n_done, 0);
    bus.load_req = 1'b0;
    step();

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        int v = int'($urandom_range(31, 1));
        d = 8'(((v / 10) << 4) | (v % 10));
      end else begin
        d = 8'($urandom);
      end
      model(d, e, l, dy);
      convert(d, e, l, dy, 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/cargador_dia_bcd.md
CARGADOR_DIA_BCD -- requirements
Module: cargador_dia_bcd

Interface
REQ-001 Parameter N, default 5, SHALL set the width of the binary day count (0..30 fits in 5 bits).
REQ-002 clk  input  1  single clock; every register SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 load_req  input  1  level request to convert data_bcd; only its rising edge SHALL be acted on.
REQ-005 data_bcd  input  8  day value in packed BCD, [7:4] tens and [3:0] units, valid range 0x01..0x31.
REQ-006 ready  output  1  high when a new request will be accepted.
REQ-007 done  output  1  one-cycle pulse when a conversion completes successfully.
REQ-008 error  output  1  one-cycle pulse when the captured value is rejected.
REQ-009 day_bin  output  N  stored day minus one (0..30), in the form consumed by the day up/down counter.

Function
REQ-010 A rising-edge detector SHALL produce load_tick = load_req AND NOT (load_req registered on the previous cycle).
REQ-011 The FSM SHALL have exactly five states: IDLE, CHECK, ACC, DONE and ERR.
REQ-012 In IDLE, a load_tick in cycle k SHALL latch data_bcd into a capture register and move to CHECK at the end of cycle k.
REQ-013 CHECK (cycle k+1) SHALL go to ERR if units > 9, tens > 3, the value equals 0x00, or the value exceeds 0x31.
REQ-014 Otherwise CHECK SHALL load acc = units and tens_cnt = tens, then go to ACC.
REQ-015 In ACC, if tens_cnt != 0, the FSM SHALL add 10 to acc, decrement tens_cnt and stay in ACC; if tens_cnt == 0, it SHALL go to DONE.
REQ-016 ACC SHALL therefore last tens+1 cycles.
REQ-017 day_bin SHALL be written with acc-1 on the edge that enters DONE.
REQ-018 done SHALL be high only during the single DONE cycle (cycle k+3+tens), and day_bin SHALL already hold the new value in that cycle.
REQ-019 DONE SHALL return to IDLE after one cycle.
REQ-020 error SHALL be high only during the single ERR cycle (cycle k+2).
REQ-021 In ERR, day_bin SHALL keep its previous value, and the FSM SHALL then return to IDLE.
REQ-022 ready SHALL equal (state == IDLE).
REQ-023 A load_tick outside IDLE SHALL be ignored and not queued.
REQ-024 The edge register SHALL keep sampling in every state.
REQ-025 done and error SHALL never be high in the same cycle.
REQ-026 All arithmetic SHALL be unsigned and held in N-bit registers.
REQ-027 acc SHALL never exceed 31, so no overflow handling is needed.
REQ-028 data_bcd SHALL be sampled only in the load_tick cycle; later changes SHALL NOT affect the conversion in progress.

Reset
REQ-029 When reset is asserted: state = IDLE, day_bin = 0, done = 0, error = 0, acc = 0, tens_cnt = 0, capture register = 0, ready = 1 in the following cycle.
REQ-030 The load_req edge register SHALL reset to 1, so a load_req held high through reset does not trigger a conversion.
REQ-031 reset SHALL abort any conversion in progress and leave day_bin at 0.
REQ-032 reset SHALL take priority over load_tick in the same cycle.

Structure
REQ-033 A shared constants include file SHALL hold: N = 5, DIA_MIN_BCD = 8'h01, DIA_MAX_BCD = 8'h31, and the state encodings (3 bits).
REQ-034 The rising-edge detector SHALL be a separate sub-module, detector_flanco (clk, reset, in, tick), reusable by the up/down counters.
REQ-035 The FSM, datapath and output logic SHALL reside in cargador_dia_bcd.

Verification
REQ-036 data_bcd = 0x15, load_req rising in cycle k -> done in k+4, day_bin = 14, error = 0.
REQ-037 data_bcd = 0x31 -> done in k+6, day_bin = 30; data_bcd = 0x01 -> done in k+3, day_bin = 0.
REQ-038 data_bcd = 0x32, 0x1A and 0x00, one request each -> error in k+2 for each, done = 0, day_bin unchanged from the prior value.
REQ-039 load_req held high for 20 cycles with data_bcd = 0x09 -> exactly one done pulse, day_bin = 8.
REQ-040 A second rising edge during ACC -> ignored; exactly one done pulse; ready low from k+1 until the DONE cycle.
REQ-041 reset asserted during ACC of a 0x31 conversion -> next cycle state = IDLE, day_bin = 0, ready = 1, and no done pulse.
